mem_port_arbiter: RTL and testbench

- Shares the single-ported data memory between the instruction-fetch path and the MEM stage.
- Each requester holds a request until it receives a one-cycle ack. The arbiter sequences a fixed-latency memory access window, returns read data and raises stall to the pipeline while a request is pending.
- MEM-stage (data) requests have priority. A streak limit guarantees that instruction fetch makes progress.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and the
// MEM stage; data has priority, a streak limit forces fetch progress.
// Revision 1.0
`default_nettype none

module mem_port_arbiter #(
  parameter int         LATENCY      = 2,
  parameter int         MAX_STREAK   = 2,
  parameter logic [1:0] IF_LOAD_MODE = 2'b00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_load_mode,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_stall,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_load_mode,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int STK_W = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_STREAK);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESPOND} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STK_W-1:0] streak_q, streak_d;
  logic             own_data_q, own_data_d;
  logic             write_q, write_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       mode_q, mode_d;
  logic [31:0]      d_rdata_q, d_rdata_d;
  logic [31:0]      i_rdata_q, i_rdata_d;
  logic             fetch_win;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      streak_q   <= '0;
      own_data_q <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mode_q     <= '0;
      d_rdata_q  <= '0;
      i_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      own_data_q <= own_data_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mode_q     <= mode_d;
      d_rdata_q  <= d_rdata_d;
      i_rdata_q  <= i_rdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    streak_d       = streak_q;
    own_data_d     = own_data_q;
    write_d        = write_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    mode_d         = mode_q;
    d_rdata_d      = d_rdata_q;
    i_rdata_d      = i_rdata_q;
    fetch_win      = 1'b0;
    d_ack          = 1'b0;
    i_ack          = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_load_mode  = '0;
    mem_address    = '0;
    mem_write_data = '0;

    case (state_q)
      S_IDLE: begin
        if (d_req || i_req) begin
          // Fetch only beats a pending data request once the streak limit is hit.
          fetch_win  = i_req && (!d_req || (streak_q == STK_MAX));
          own_data_d = !fetch_win;
          write_d    = !fetch_win && d_write;
          addr_d     = fetch_win ? i_addr : d_addr;
          wdata_d    = d_wdata;
          mode_d     = fetch_win ? IF_LOAD_MODE : d_load_mode;
          cnt_d      = CNT_LOAD;
          state_d    = S_ACCESS;
          if (fetch_win || !i_req) streak_d = '0;
          else if (streak_q != STK_MAX) streak_d = streak_q + 1'b1;
        end
      end
      S_ACCESS: begin
        mem_read       = !write_q;
        mem_write      = write_q;
        mem_address    = addr_q;
        mem_load_mode  = mode_q;
        mem_write_data = own_data_q ? wdata_q : '0;
        cnt_d          = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          if (!write_q) begin
            if (own_data_q) d_rdata_d = mem_read_data;
            else            i_rdata_d = mem_read_data;
          end
          state_d = S_RESPOND;
        end
      end
      S_RESPOND: begin
        d_ack   = own_data_q;
        i_ack   = !own_data_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign d_rdata = d_rdata_q;
  assign i_rdata = i_rdata_q;
  assign d_stall = d_req && !d_ack;
  assign i_stall = i_req && !i_ack;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed literal checks plus randomized traffic compared every
// cycle against a transaction-timeline model of the arbiter.
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int MAXS = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, d_req, d_write, i_req;
  logic [31:0] d_addr, d_wdata, i_addr, mem_read_data;
  logic [1:0]  d_load_mode;
  logic        d_ack, d_stall, i_ack, i_stall, mem_read, mem_write;
  logic [31:0] d_rdata, i_rdata, mem_address, mem_write_data;
  logic [1:0]  mem_load_mode;

  mem_port_arbiter #(.LATENCY(LAT), .MAX_STREAK(MAXS), .IF_LOAD_MODE(2'b00)) u_dut (
    .clk(clk), .reset(reset),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_load_mode(d_load_mode), .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_stall(i_stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_load_mode(mem_load_mode),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  // Single-cycle-latency build, exercised with a directed fetch only.
  logic        i_req1 = 1'b0;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'h0, mrd1 = 32'h0;
  logic [1:0]  zero2 = 2'b00;
  logic        d_ack1, d_stall1, i_ack1, i_stall1, mr1, mw1;
  logic [31:0] d_rdata1, i_rdata1, ma1, mwd1;
  logic [1:0]  mlm1;

  mem_port_arbiter #(.LATENCY(1), .MAX_STREAK(MAXS), .IF_LOAD_MODE(2'b00)) u_dut1 (
    .clk(clk), .reset(reset),
    .d_req(zero1), .d_write(zero1), .d_addr(zero32), .d_wdata(zero32),
    .d_load_mode(zero2), .d_ack(d_ack1), .d_rdata(d_rdata1), .d_stall(d_stall1),
    .i_req(i_req1), .i_addr(zero32), .i_ack(i_ack1), .i_rdata(i_rdata1), .i_stall(i_stall1),
    .mem_read(mr1), .mem_write(mw1), .mem_load_mode(mlm1),
    .mem_address(ma1), .mem_write_data(mwd1), .mem_read_data(mrd1)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: one outstanding transaction described by its grant cycle; strobes occupy
  // the LAT cycles after the grant and the ack lands one cycle later.
  bit          chk_en   = 1'b0;
  bit          m_act    = 1'b0;
  int          m_gt     = 0;
  bit          m_data   = 1'b0;
  bit          m_wr     = 1'b0;
  logic [31:0] m_addr   = 32'h0;
  logic [31:0] m_wd     = 32'h0;
  logic [1:0]  m_mode   = 2'b00;
  int          m_streak = 0;
  logic [31:0] m_drd    = 32'h0;
  logic [31:0] m_ird    = 32'h0;

  always @(negedge clk) begin
    int ph;
    bit acc, ack, rd;
    if (chk_en) begin
      ph  = m_act ? (cyc - m_gt) : -1;
      acc = m_act && (ph >= 1) && (ph <= LAT);
      ack = m_act && (ph == LAT + 1);
      rd  = !m_data || !m_wr;
      chk1 ("mem_read",       mem_read,  acc && rd);
      chk1 ("mem_write",      mem_write, acc && !rd);
      chk32("mem_address",    mem_address, acc ? m_addr : 32'h0);
      chk32("mem_write_data", mem_write_data, (acc && m_data) ? m_wd : 32'h0);
      chk32("mem_load_mode",  {30'h0, mem_load_mode},
            {30'h0, (acc && m_data) ? m_mode : 2'b00});
      chk1 ("d_ack",   d_ack,   ack && m_data);
      chk1 ("i_ack",   i_ack,   ack && !m_data);
      chk1 ("d_stall", d_stall, d_req && !(ack && m_data));
      chk1 ("i_stall", i_stall, i_req && !(ack && !m_data));
      chk32("d_rdata", d_rdata, m_drd);
      chk32("i_rdata", i_rdata, m_ird);

      if (reset) begin
        m_act = 1'b0; m_streak = 0; m_drd = 32'h0; m_ird = 32'h0;
      end else if (m_act) begin
        if (ph == LAT && rd) begin
          if (m_data) m_drd = mem_read_data;
          else        m_ird = mem_read_data;
        end
        if (ph == LAT + 1) m_act = 1'b0;
      end else if (d_req || i_req) begin
        m_data = d_req && !(i_req && (m_streak == MAXS));
        m_wr   = m_data && d_write;
        m_addr = m_data ? d_addr : i_addr;
        m_wd   = d_wdata;
        m_mode = d_load_mode;
        if (m_data && i_req) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
        else                 m_streak = 0;
        m_act = 1'b1;
        m_gt  = cyc;
      end
    end
    cyc++;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic obs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; d_req = 1'b0; i_req = 1'b0; d_write = 1'b0;
    nxt();
    nxt();
    reset = 1'b0;
  endtask

  bit exp_ord [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  bit ord [6];

  initial begin
    int n;
    bit dseen, iseen, was;
    reset = 1'b1; d_req = 1'b0; d_write = 1'b0; i_req = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; i_addr = 32'h0; d_load_mode = 2'b00;
    mem_read_data = 32'h0;
    nxt();
    chk_en = 1'b1;
    obs();
    chk1 ("rst mem_read", mem_read, 1'b0);
    chk32("rst mem_address", mem_address, 32'h0);
    chk1 ("rst d_ack", d_ack, 1'b0);
    chk32("rst d_rdata", d_rdata, 32'h0);
    chk32("rst i_rdata", i_rdata, 32'h0);
    nxt();
    reset = 1'b0;

    // LATENCY=1 fetch: strobe only in cycle 1, ack in cycle 2.
    i_req1 = 1'b1; mrd1 = 32'hA5A5_0001;
    obs(); chk1("lat1 c0 mem_read", mr1, 1'b0);
    nxt(); obs(); chk1("lat1 c1 mem_read", mr1, 1'b1);
    nxt(); obs(); chk1("lat1 c2 mem_read", mr1, 1'b0);
    chk1("lat1 c2 i_ack", i_ack1, 1'b1);
    chk32("lat1 i_rdata", i_rdata1, 32'hA5A5_0001);
    nxt(); i_req1 = 1'b0;

    // Data read at 0x10.
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h10; d_load_mode = 2'b01;
    mem_read_data = 32'hDEAD_BEEF;
    obs(); chk1("rd c0 d_stall", d_stall, 1'b1);
    nxt(); obs(); chk1("rd c1 mem_read", mem_read, 1'b1);
    chk32("rd c1 mem_address", mem_address, 32'h10);
    nxt(); obs(); chk1("rd c2 mem_read", mem_read, 1'b1);
    chk1("rd c2 d_stall", d_stall, 1'b1);
    nxt(); obs(); chk1("rd c3 d_ack", d_ack, 1'b1);
    chk32("rd c3 d_rdata", d_rdata, 32'hDEAD_BEEF);
    chk1("rd c3 d_stall", d_stall, 1'b0);
    nxt(); d_req = 1'b0;

    // Data write at 0x20.
    nxt();
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234_5678;
    nxt(); obs(); chk1("wr c1 mem_write", mem_write, 1'b1);
    chk1("wr c1 mem_read", mem_read, 1'b0);
    chk32("wr c1 mem_address", mem_address, 32'h20);
    chk32("wr c1 mem_write_data", mem_write_data, 32'h1234_5678);
    nxt(); obs(); chk1("wr c2 mem_write", mem_write, 1'b1);
    nxt(); obs(); chk1("wr c3 d_ack", d_ack, 1'b1);
    chk32("wr c3 d_rdata", d_rdata, 32'hDEAD_BEEF);
    nxt(); d_req = 1'b0; d_write = 1'b0;

    // Simultaneous requests: data first, fetch granted at cycle 4.
    do_reset();
    d_req = 1'b1; d_addr = 32'h30; i_req = 1'b1; i_addr = 32'h40;
    mem_read_data = 32'hCAFE_F00D;
    nxt(); nxt();
    nxt(); obs(); chk1("sim c3 d_ack", d_ack, 1'b1);
    chk1("sim c3 i_ack", i_ack, 1'b0);
    nxt(); d_req = 1'b0;
    obs(); chk1("sim c4 mem_read", mem_read, 1'b0);
    nxt(); obs(); chk1("sim c5 mem_read", mem_read, 1'b1);
    chk32("sim c5 mem_address", mem_address, 32'h40);
    chk32("sim c5 mem_load_mode", {30'h0, mem_load_mode}, 32'h0);
    nxt(); nxt(); obs(); chk1("sim c7 i_ack", i_ack, 1'b1);
    chk32("sim c7 i_rdata", i_rdata, 32'hCAFE_F00D);
    chk1("sim c7 i_stall", i_stall, 1'b0);
    nxt(); i_req = 1'b0;

    // Starvation guard: both held, grant order D D I D D I.
    do_reset();
    d_req = 1'b1; i_req = 1'b1;
    n = 0;
    for (int k = 0; k < 60 && n < 6; k++) begin
      obs();
      if (d_ack)      begin ord[n] = 1'b1; n++; end
      else if (i_ack) begin ord[n] = 1'b0; n++; end
      nxt();
    end
    d_req = 1'b0; i_req = 1'b0;
    chk32("streak grant count", n, 32'd6);
    for (int k = 0; k < n; k++) chk1("streak grant order", ord[k], exp_ord[k]);

    // Reset in cycle 2 of a data access; held request re-served with full latency.
    do_reset();
    d_req = 1'b1; d_addr = 32'h50; mem_read_data = 32'h0BAD_F00D;
    nxt(); nxt();
    reset = 1'b1;
    obs(); chk1("rst-mid c2 mem_read", mem_read, 1'b1);
    nxt(); reset = 1'b0;
    obs(); chk1("rst-mid c3 mem_read", mem_read, 1'b0);
    chk1("rst-mid c3 d_ack", d_ack, 1'b0);
    chk32("rst-mid c3 mem_address", mem_address, 32'h0);
    chk32("rst-mid c3 d_rdata", d_rdata, 32'h0);
    nxt(); nxt();
    nxt(); obs(); chk1("rst-mid c6 d_ack", d_ack, 1'b1);
    nxt(); d_req = 1'b0;

    // Randomized traffic against the model.
    dseen = 1'b0; iseen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 99) == 0);
      mem_read_data = $urandom;
      was = d_req;
      if (dseen)       d_req = ($urandom_range(0, 3) == 0);
      else if (!d_req) d_req = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 49) == 0) d_req = 1'b0;
      if (d_req && (!was || dseen)) begin
        d_write = $urandom_range(0, 1) == 1;
        d_addr = $urandom; d_wdata = $urandom;
        d_load_mode = 2'($urandom_range(0, 3));
      end else if ($urandom_range(0, 29) == 0) begin
        d_addr = $urandom;
      end
      was = i_req;
      if (iseen)       i_req = ($urandom_range(0, 2) != 0);
      else if (!i_req) i_req = ($urandom_range(0, 1) == 0);
      else if ($urandom_range(0, 49) == 0) i_req = 1'b0;
      if (i_req && (!was || iseen)) i_addr = $urandom;
      obs();
      dseen = d_ack;
      iseen = i_ack;
      nxt();
    end

    reset = 1'b0; d_req = 1'b0; i_req = 1'b0;
    repeat (6) nxt();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
